nibble_serial_addsub: RTL and testbench

Multi-cycle WIDTH-bit adder/subtractor that reuses a single 4-bit carry-lookahead adder, one nibble per clock, LSB nibble first. Sits directly above the 4-bit adder stage in the AddSub path: latches operands, feeds nibbles and the rippled carry into the adder each cycle, and assembles the full result and status flags (C, V, Z, N) for the ALU. Trades latency for area; valid/ready on both sides.

---
 rtl/nibble_serial_addsub_pkg.sv | 18 +
 rtl/nibble_serial_addsub_adder.sv | 33 +++
 rtl/nibble_serial_addsub.sv | 124 ++++++++++++
 tb/tb_nibble_serial_addsub.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor: FSM encoding,
// nibble size and the nibble-index counter width.
package nibble_serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIBBLE = 4;

   // Width of a counter addressing every nibble of a width-bit operand.
   function automatic int idx_width(input int width);
      return $clog2(width / NIBBLE);
   endfunction

endpackage

// File: rtl/nibble_serial_addsub_adder.sv
// 4-bit carry-lookahead adder shared across all nibbles. cin_msb is the carry
// into bit 3, used to derive signed overflow on the most significant nibble.
module fourBitAdder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout,
   output logic       cin_msb
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is a flat sum-of-products of generate/propagate terms.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign sum     = p ^ c[3:0];
   assign cout    = c[4];
   assign cin_msb = c[3];

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single 4-bit
// CLA, LSB nibble first, with valid/ready handshakes and C/V/Z/N flags.
module nibble_serial_addsub
   import nibble_serial_addsub_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int            NNIB = WIDTH / NIBBLE;
   localparam int            CW   = idx_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(NNIB - 1);

   state_t           state_q;
   logic [CW-1:0]    idx_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result_d;
   logic             cout_q;
   logic             ovf_q;
   logic             in_ready_q;
   logic             out_valid_q;

   logic [NIBBLE-1:0] a_nibs [NNIB];
   logic [NIBBLE-1:0] b_nibs [NNIB];
   logic [NIBBLE-1:0] nib_sum;
   logic              nib_cout;
   logic              nib_cin_msb;

   // Split operands into nibble arrays and merge the new sum into its slot.
   for (genvar gi = 0; gi < NNIB; gi++) begin : g_nib
      assign a_nibs[gi] = a_q[gi*NIBBLE +: NIBBLE];
      assign b_nibs[gi] = b_q[gi*NIBBLE +: NIBBLE];
      assign result_d[gi*NIBBLE +: NIBBLE] =
         (idx_q == CW'(gi)) ? nib_sum : result_q[gi*NIBBLE +: NIBBLE];
   end

   fourBitAdder u_adder (
      .a       (a_nibs[idx_q]),
      .b       (b_nibs[idx_q]),
      .cin     (carry_q),
      .sum     (nib_sum),
      .cout    (nib_cout),
      .cin_msb (nib_cin_msb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         result_q    <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction is A + ~B + 1: invert B once, seed the carry.
                  a_q        <= a;
                  b_q        <= sub ? ~b : b;
                  carry_q    <= sub;
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               result_q <= result_d;
               carry_q  <= nib_cout;
               idx_q    <= idx_q + 1'b1;
               if (idx_q == LAST) begin
                  ovf_q       <= nib_cout ^ nib_cin_msb;
                  cout_q      <= nib_cout;
                  idx_q       <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = (result_q == '0);
   assign neg       = result_q[WIDTH-1];

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench for nibble_serial_addsub: expected results are queued at
// stimulus time from a behavioural model and popped when out_valid appears.
module tb_nibble_serial_addsub;

   localparam int W    = 32;
   localparam int NNIB = W / 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic         zero;
   logic         neg;

   typedef struct packed {
      logic [W-1:0] res;
      logic         c;
      logic         v;
      logic         z;
      logic         n;
   } resp_t;

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         s;
   } op_t;

   resp_t sb[$];
   int    checks   = 0;
   int    failures = 0;

   nibble_serial_addsub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero),
      .neg       (neg)
   );

   always #5 clk = ~clk;

   function automatic resp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      resp_t r;
      logic [W:0] full;
      if (s) begin
         r.res = x - y;
         r.c   = (x >= y);
         r.v   = (x[W-1] != y[W-1]) && (r.res[W-1] != x[W-1]);
      end else begin
         full  = {1'b0, x} + {1'b0, y};
         r.res = full[W-1:0];
         r.c   = full[W];
         r.v   = (x[W-1] == y[W-1]) && (r.res[W-1] != x[W-1]);
      end
      r.z = (r.res == '0);
      r.n = r.res[W-1];
      return r;
   endfunction

   function automatic resp_t observed();
      return {result, cout, ovf, zero, neg};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for in_ready, presents one operation for one cycle.
   task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                           output int waited);
      waited = 0;
      while (!in_ready && waited < 50) begin
         tick();
         waited++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL start_timeout in_ready=%b required=1", in_ready);
         return;
      end
      a        = x;
      b        = y;
      sub      = s;
      in_valid = 1'b1;
      sb.push_back(model(x, y, s));
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 50) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      resp_t rst_exp;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      sub       = 1'b0;
      repeat (3) tick();
      rst_exp = {{W{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0};
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%b exp=1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_out_valid got=%b exp=0", out_valid);
      end
      checks++;
      if (observed() !== rst_exp) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=%h", observed(), rst_exp);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      op_t   ops[6];
      resp_t exp;
      int    w;
      int    cyc;
      ops[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
      ops[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0};
      ops[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1};
      ops[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1};
      ops[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1};
      ops[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1};
      out_ready = 1'b1;
      foreach (ops[i]) begin
         start_op(ops[i].x, ops[i].y, ops[i].s, w);
         wait_out(cyc);
         checks++;
         if (cyc !== NNIB) begin
            failures++;
            $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, cyc, NNIB);
         end
         exp = sb.pop_front();
         checks++;
         if (observed() !== exp) begin
            failures++;
            $display("FAIL directed_result[%0d] got=%h exp=%h", i, observed(), exp);
         end
         $display("txn directed a=%h b=%h sub=%b result=%h c=%b v=%b z=%b n=%b",
                  ops[i].x, ops[i].y, ops[i].s, result, cout, ovf, zero, neg);
         tick();
      end
   endtask

   task automatic test_backpressure();
      resp_t exp;
      resp_t snap;
      int    w;
      int    cyc;
      out_ready = 1'b0;
      start_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, w);
      wait_out(cyc);
      snap = observed();
      exp  = sb.pop_front();
      checks++;
      if (snap !== exp) begin
         failures++;
         $display("FAIL bp_result got=%h exp=%h", snap, exp);
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         a        = $urandom;
         b        = $urandom;
         sub      = 1'($urandom_range(0, 1));
         tick();
         checks++;
         if (observed() !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold[%0d] got=%h in_ready=%b out_valid=%b exp=%h in_ready=0 out_valid=1",
                     i, observed(), in_ready, out_valid, exp);
         end
      end
      a         = 32'h0000_0100;
      b         = 32'h0000_0023;
      sub       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_release in_ready=%b out_valid=%b exp in_ready=1 out_valid=0",
                  in_ready, out_valid);
      end
      sb.push_back(model(32'h0000_0100, 32'h0000_0023, 1'b1));
      tick();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_accept in_ready=%b exp=0", in_ready);
      end
      wait_out(cyc);
      checks++;
      if (cyc !== NNIB) begin
         failures++;
         $display("FAIL bp_latency got=%0d exp=%0d", cyc, NNIB);
      end
      exp = sb.pop_front();
      checks++;
      if (observed() !== exp) begin
         failures++;
         $display("FAIL bp_second got=%h exp=%h", observed(), exp);
      end
      $display("txn backpressure a=00000100 b=00000023 sub=1 result=%h c=%b", result, cout);
      tick();
   endtask

   task automatic test_reset_busy();
      resp_t exp;
      int    w;
      int    cyc;
      out_ready = 1'b1;
      start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, w);
      repeat (3) tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rb_busy_out_valid got=%b exp=0", out_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      void'(sb.pop_back());
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || ovf !== 1'b0 || cout !== 1'b0) begin
         failures++;
         $display("FAIL rb_after_reset in_ready=%b out_valid=%b result=%h ovf=%b cout=%b exp 1 0 0 0 0",
                  in_ready, out_valid, result, ovf, cout);
      end
      start_op(32'h0000_0010, 32'h0000_0020, 1'b0, w);
      wait_out(cyc);
      exp = sb.pop_front();
      checks++;
      if (observed() !== exp || result !== 32'h0000_0030) begin
         failures++;
         $display("FAIL rb_fresh got=%h exp=%h", observed(), exp);
      end
      $display("txn reset_busy a=00000010 b=00000020 sub=0 result=%h c=%b", result, cout);
      tick();
   endtask

   task automatic test_back_to_back();
      resp_t        exp;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         s;
      int           w;
      int           cyc;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         x = (i == 0) ? 32'h8000_0000 : $urandom;
         y = (i == 1) ? 32'h7FFF_FFFF : $urandom;
         s = 1'(i % 2);
         start_op(x, y, s, w);
         if (i > 0) begin
            checks++;
            if (w !== 1) begin
               failures++;
               $display("FAIL b2b_interval[%0d] wait=%0d exp=1", i, w);
            end
         end
         wait_out(cyc);
         exp = sb.pop_front();
         checks++;
         if (observed() !== exp) begin
            failures++;
            $display("FAIL b2b_result[%0d] got=%h exp=%h", i, observed(), exp);
         end
         $display("txn b2b a=%h b=%h sub=%b result=%h c=%b v=%b", x, y, s, result, cout, ovf);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_busy();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
